// File: rtl/gate_bist_pkg.sv
// Shared types and constants for the gate-bank self-test sequencer and its
// expected-value model.
package gate_bist_pkg;

    localparam int NUM_GATES = 7;

    localparam int GI_NOT  = 0;
    localparam int GI_AND  = 1;
    localparam int GI_OR   = 2;
    localparam int GI_NAND = 3;
    localparam int GI_NOR  = 4;
    localparam int GI_XOR  = 5;
    localparam int GI_XNOR = 6;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_CHECK  = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

endpackage

// File: rtl/gate_bist_seq_ref.sv
// Combinational expected outputs of the 2-input gate bank. The bit order
// matches gate_y on the sequencer.
module gate_ref_model
    import gate_bist_pkg::*;
(
    input  logic                 a,
    input  logic                 b,
    output logic [NUM_GATES-1:0] y
);

    always_comb begin
        y          = '0;
        y[GI_NOT]  = ~a;
        y[GI_AND]  = a & b;
        y[GI_OR]   = a | b;
        y[GI_NAND] = ~(a & b);
        y[GI_NOR]  = ~(a | b);
        y[GI_XOR]  = a ^ b;
        y[GI_XNOR] = ~(a ^ b);
    end

endmodule

// File: rtl/gate_bist_seq.sv
// Sweep-and-check self-test sequencer for the 2-input gate bank.
// Define GATE_BIST_ERR_INJECT_EN to add the inj_mask port that flips expected bits.
module gate_bist_seq
    import gate_bist_pkg::*;
#(
    parameter int SETTLE_CYC = 2,
    parameter int NUM_PASSES = 1,
    parameter int CNT_W      = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
`ifdef GATE_BIST_ERR_INJECT_EN
    input  logic [NUM_GATES-1:0] inj_mask,
`endif
    output logic                 a,
    output logic                 b,
    input  logic [NUM_GATES-1:0] gate_y,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [CNT_W-1:0]     err_cnt,
    output logic [NUM_GATES-1:0] fail_vec,
    output logic [1:0]           first_fail_ab
);

    localparam int SC_W = (SETTLE_CYC > 0) ? $clog2(SETTLE_CYC + 1) : 1;
    localparam int PC_W = (NUM_PASSES > 1) ? $clog2(NUM_PASSES) : 1;
    localparam logic [SC_W-1:0]  SETTLE_LOAD = SC_W'(SETTLE_CYC);
    localparam logic [PC_W-1:0]  LAST_SWEEP  = PC_W'(NUM_PASSES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX     = '1;

    state_e                 state_q, state_d;
    logic [1:0]             vec_q, vec_d;
    logic [PC_W-1:0]        sweep_cnt_q, sweep_cnt_d;
    logic [SC_W-1:0]        settle_cnt_q, settle_cnt_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   pass_q, pass_d;
    logic [CNT_W-1:0]       err_cnt_q, err_cnt_d;
    logic [NUM_GATES-1:0]   fail_vec_q, fail_vec_d;
    logic [1:0]             first_fail_ab_q, first_fail_ab_d;

    logic [NUM_GATES-1:0]   ref_y;
    logic [NUM_GATES-1:0]   exp_y;
    logic [NUM_GATES-1:0]   mism;
    logic [CNT_W-1:0]       err_upd;
    logic                   last_vec;

    gate_ref_model u_ref (
        .a (vec_q[1]),
        .b (vec_q[0]),
        .y (ref_y)
    );

`ifdef GATE_BIST_ERR_INJECT_EN
    assign exp_y = ref_y ^ inj_mask;
`else
    assign exp_y = ref_y;
`endif

    assign mism     = gate_y ^ exp_y;
    assign last_vec = (vec_q == 2'b11) && (sweep_cnt_q == LAST_SWEEP);
    // Saturating error count including the vector under check this cycle.
    assign err_upd  = ((mism != '0) && (err_cnt_q != CNT_MAX)) ? err_cnt_q + 1'b1 : err_cnt_q;

    always_comb begin
        state_d         = state_q;
        vec_d           = vec_q;
        sweep_cnt_d     = sweep_cnt_q;
        settle_cnt_d    = settle_cnt_q;
        busy_d          = busy_q;
        done_d          = 1'b0;
        pass_d          = pass_q;
        err_cnt_d       = err_cnt_q;
        fail_vec_d      = fail_vec_q;
        first_fail_ab_d = first_fail_ab_q;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    err_cnt_d       = '0;
                    fail_vec_d      = '0;
                    first_fail_ab_d = 2'b00;
                    pass_d          = 1'b0;
                    vec_d           = 2'b00;
                    sweep_cnt_d     = '0;
                    settle_cnt_d    = SETTLE_LOAD;
                    busy_d          = 1'b1;
                    state_d         = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (settle_cnt_q == '0) begin
                    state_d = ST_CHECK;
                end else begin
                    settle_cnt_d = settle_cnt_q - 1'b1;
                end
            end
            ST_CHECK: begin
                err_cnt_d = err_upd;
                if (mism != '0) begin
                    fail_vec_d = fail_vec_q | mism;
                    // err_cnt never returns to zero within a run, so zero means no earlier error.
                    if (err_cnt_q == '0) begin
                        first_fail_ab_d = vec_q;
                    end
                end
                if (!last_vec) begin
                    vec_d        = vec_q + 2'd1;
                    settle_cnt_d = SETTLE_LOAD;
                    state_d      = ST_SETTLE;
                    if (vec_q == 2'b11) begin
                        sweep_cnt_d = sweep_cnt_q + 1'b1;
                    end
                end else begin
                    done_d  = 1'b1;
                    pass_d  = (err_upd == '0);
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= ST_IDLE;
            vec_q           <= 2'b00;
            sweep_cnt_q     <= '0;
            settle_cnt_q    <= '0;
            busy_q          <= 1'b0;
            done_q          <= 1'b0;
            pass_q          <= 1'b0;
            err_cnt_q       <= '0;
            fail_vec_q      <= '0;
            first_fail_ab_q <= 2'b00;
        end else begin
            state_q         <= state_d;
            vec_q           <= vec_d;
            sweep_cnt_q     <= sweep_cnt_d;
            settle_cnt_q    <= settle_cnt_d;
            busy_q          <= busy_d;
            done_q          <= done_d;
            pass_q          <= pass_d;
            err_cnt_q       <= err_cnt_d;
            fail_vec_q      <= fail_vec_d;
            first_fail_ab_q <= first_fail_ab_d;
        end
    end

    assign a             = vec_q[1];
    assign b             = vec_q[0];
    assign busy          = busy_q;
    assign done          = done_q;
    assign pass          = pass_q;
    assign err_cnt       = err_cnt_q;
    assign fail_vec      = fail_vec_q;
    assign first_fail_ab = first_fail_ab_q;

endmodule

// File: tb/tb_gate_bist_seq.sv
// Bench for gate_bist_seq: three parameter sets, each driving a gate bank with
// configurable per-vector faults and checked cycle by cycle against a run-level model.
module tb_gate_bist_seq;

    localparam int S_TAB [3] = '{2, 2, 0};
    localparam int P_TAB [3] = '{1, 3, 1};
    localparam int W_TAB [3] = '{8, 8, 2};

    localparam int DONE_T  [3] = '{17, 49, 9};
    localparam int GAP_T   [3] = '{18, 50, 10};
    localparam int F_ERR   [3] = '{2, 6, 3};
    localparam int F_FV    [3] = '{32'h20, 32'h20, 32'h7F};
    localparam int F_FF    [3] = '{1, 1, 0};
    localparam int INJ_ERR [3] = '{4, 12, 3};
    localparam logic [6:0] FT [3][4] = '{
        '{7'h00, 7'h20, 7'h20, 7'h00},
        '{7'h00, 7'h20, 7'h20, 7'h00},
        '{7'h7F, 7'h7F, 7'h7F, 7'h7F}
    };

    logic clk;
    int   nvec;
    int   nerr;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [6:0] gates(input logic x, input logic y);
        return {~(x ^ y), x ^ y, ~(x | y), ~(x & y), x | y, x & y, ~x};
    endfunction

    task automatic chk(input string nm, input int inst, input logic [31:0] got, input logic [31:0] want);
        nvec++;
        if (got !== want) begin
            nerr++;
            $display("FAIL %s inst%0d t=%0t got=%0h want=%0h", nm, inst, $time, got, want);
        end
    endtask

    for (genvar gi = 0; gi < 3; gi++) begin : g_inst
        localparam int S = S_TAB[gi];
        localparam int P = P_TAB[gi];
        localparam int W = W_TAB[gi];
        localparam int L = 4 * P * (S + 2) + 1;

        logic         rst_n, start, a, b, busy, done, pass;
        logic [6:0]   gate_y, fail_vec, inj_mask;
        logic [W-1:0] err_cnt;
        logic [1:0]   ffab;
        logic [6:0]   flip_tab [4];
        bit           fin;

        assign gate_y = gates(a, b) ^ flip_tab[{a, b}];

        gate_bist_seq #(.SETTLE_CYC(S), .NUM_PASSES(P), .CNT_W(W)) dut (
            .clk           (clk),
            .rst_n         (rst_n),
            .start         (start),
`ifdef GATE_BIST_ERR_INJECT_EN
            .inj_mask      (inj_mask),
`endif
            .a             (a),
            .b             (b),
            .gate_y        (gate_y),
            .busy          (busy),
            .done          (done),
            .pass          (pass),
            .err_cnt       (err_cnt),
            .fail_vec      (fail_vec),
            .first_fail_ab (ffab)
        );

        // Run-level model: m_t is the cycle index since the accepted start edge.
        bit         m_run, m_has;
        int         m_t;
        bit [1:0]   m_ab;
        logic [6:0] m_tab [4];

        always @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                m_run <= 1'b0;
                m_has <= 1'b0;
                m_t   <= 0;
                m_ab  <= 2'b00;
            end else if (m_run) begin
                if (m_t == L) begin
                    m_run <= 1'b0;
                    m_has <= 1'b1;
                    m_ab  <= 2'b11;
                end else begin
                    m_t <= m_t + 1;
                end
            end else if (start) begin
                m_run <= 1'b1;
                m_has <= 1'b0;
                m_t   <= 1;
                for (int i = 0; i < 4; i++) m_tab[i] <= flip_tab[i] ^ inj_mask;
            end
        end

        initial begin
            int n, cnt;
            logic [6:0] fv, f;
            logic [1:0] ff, eab;
            bit seen, ep;
            forever begin
                @(negedge clk);
                n = m_run ? (m_t - 1) / (S + 2) : (m_has ? 4 * P : 0);
                cnt = 0; fv = 7'h00; ff = 2'b00; seen = 1'b0;
                for (int g = 0; g < n; g++) begin
                    f = m_tab[g % 4];
                    if (f != 7'h00) begin
                        cnt++;
                        fv = fv | f;
                        if (!seen) begin
                            ff = 2'(g % 4);
                            seen = 1'b1;
                        end
                    end
                end
                if (cnt > (1 << W) - 1) cnt = (1 << W) - 1;
                ep  = ((m_run && m_t == L) || (!m_run && m_has)) && (cnt == 0);
                eab = !m_run ? m_ab : ((m_t < L) ? 2'(((m_t - 1) / (S + 2)) % 4) : 2'b11);
                chk("busy", gi, busy, m_run);
                chk("done", gi, done, m_run && m_t == L);
                chk("pass", gi, pass, ep);
                chk("ab", gi, {a, b}, eab);
                chk("err_cnt", gi, err_cnt, cnt);
                chk("fail_vec", gi, fail_vec, fv);
                chk("first_fail_ab", gi, ffab, ff);
            end
        end

        task automatic wait_done(output int cyc);
            cyc = 0;
            do begin
                @(negedge clk);
                cyc++;
            end while (!done && cyc < 4000);
            if (!done) chk("done_timeout", gi, cyc, 0);
        endtask

        task automatic run_wait(output int cyc);
            @(posedge clk); #1 start = 1'b1;
            @(posedge clk); #1 start = 1'b0;
            wait_done(cyc);
            @(negedge clk);
        endtask

        task automatic wait_idle();
            int c;
            c = 0;
            while (busy && c < 4000) begin
                @(negedge clk);
                c++;
            end
            if (busy) chk("idle_timeout", gi, c, 0);
        endtask

        initial begin
            int c;
            rst_n = 1'b1; start = 1'b0; inj_mask = 7'h00; fin = 1'b0;
            for (int i = 0; i < 4; i++) flip_tab[i] = 7'h00;
            #2 rst_n = 1'b0;
            repeat (2) @(negedge clk);
            chk("rst_busy", gi, busy, 0);
            chk("rst_err", gi, err_cnt, 0);
            chk("rst_ab", gi, {a, b}, 0);
            @(posedge clk); #1 rst_n = 1'b1;

            run_wait(c);
            chk("clean_done_cyc", gi, c, DONE_T[gi]);
            chk("clean_pass", gi, pass, 1);
            chk("clean_err", gi, err_cnt, 0);
            chk("clean_fv", gi, fail_vec, 0);
            chk("clean_ff", gi, ffab, 0);

            for (int i = 0; i < 4; i++) flip_tab[i] = FT[gi][i];
            run_wait(c);
            chk("fault_err", gi, err_cnt, F_ERR[gi]);
            chk("fault_fv", gi, fail_vec, F_FV[gi]);
            chk("fault_ff", gi, ffab, F_FF[gi]);
            chk("fault_pass", gi, pass, 0);

            for (int i = 0; i < 4; i++) flip_tab[i] = 7'h00;
            @(posedge clk); #1 start = 1'b1;
            @(posedge clk); #1 start = 1'b0;
            repeat (2 * (S + 2) + 1) @(negedge clk);
            chk("mid_ab", gi, {a, b}, 2'b10);
            chk("mid_busy", gi, busy, 1);
            #1 rst_n = 1'b0;
            #1;
            chk("mid_rst_busy", gi, busy, 0);
            chk("mid_rst_ab", gi, {a, b}, 0);
            chk("mid_rst_pass", gi, pass, 0);
            @(posedge clk); #1 rst_n = 1'b1;
            run_wait(c);
            chk("post_rst_pass", gi, pass, 1);
            chk("post_rst_done_cyc", gi, c, DONE_T[gi]);

            @(posedge clk); #1 start = 1'b1;
            @(posedge clk);
            wait_done(c);
            chk("held_first_done", gi, c, DONE_T[gi]);
            wait_done(c);
            chk("held_done_gap", gi, c, GAP_T[gi]);
            @(posedge clk); #1 start = 1'b0;
            wait_idle();

`ifdef GATE_BIST_ERR_INJECT_EN
            inj_mask = 7'b0000010;
            run_wait(c);
            chk("inj_err", gi, err_cnt, INJ_ERR[gi]);
            chk("inj_fv", gi, fail_vec, 7'b0000010);
            inj_mask = 7'h00;
`endif

            for (int k = 0; k < 900; k++) begin
                @(posedge clk); #1;
                if (!busy && $urandom_range(0, 3) == 0) begin
                    for (int i = 0; i < 4; i++)
                        flip_tab[i] = ($urandom_range(0, 1) == 1) ? 7'h00 : 7'($urandom_range(1, 127));
                end
                start = ($urandom_range(0, 3) == 0);
                if ($urandom_range(0, 299) == 0) begin
                    rst_n = 1'b0;
                    @(negedge clk);
                    #1 rst_n = 1'b1;
                end
            end
            start = 1'b0;
            wait_idle();
            fin = 1'b1;
        end
    end

    initial begin
        int c;
        nvec = 0;
        nerr = 0;
        c = 0;
        while (!(g_inst[0].fin && g_inst[1].fin && g_inst[2].fin) && c < 60000) begin
            @(negedge clk);
            c++;
        end
        if (c >= 60000) chk("global_timeout", 0, c, 0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
